// File: rtl/tx_framer_pkg.sv
// rtl/tx_framer_pkg.sv - state type, framing constants and bytewise CRC-8 update for the TX packet framer
package tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_LEN,
        ST_PAY,
        ST_CRC,
        ST_FIN
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_dibit_shifter.sv
// rtl/tx_dibit_shifter.sv - byte-to-dibit serialiser, MSB first, with byte boundary strobe
module tx_dibit_shifter
    import tx_framer_pkg::*;
#(
    parameter logic [1:0] IDLE_SYM = 2'b00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic       i_shift,
    input  logic       i_clear,
    output logic [1:0] o_sym,
    output logic       o_byte_boundary
);

    logic [7:0] r_shift;
    logic [1:0] r_cnt;
    logic [1:0] r_sym;

    // The 4th dibit of a byte leaves on the same strobe that loads the next byte.
    assign o_byte_boundary = i_shift && (r_cnt == 2'd3);
    assign o_sym           = r_sym;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= 8'h00;
            r_cnt   <= 2'd0;
            r_sym   <= IDLE_SYM;
        end else begin
            if (i_clear) begin
                r_sym <= IDLE_SYM;
            end else if (i_shift) begin
                r_sym <= r_shift[7:6];
            end
            if (i_load) begin
                r_shift <= i_load_data;
                r_cnt   <= 2'd0;
            end else if (i_shift) begin
                r_shift <= {r_shift[5:0], 2'b00};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/tx_packet_framer.sv
// rtl/tx_packet_framer.sv - frames FIFO payload as preamble/SFD/length/payload[/CRC-8] dibit symbols
// Optional trailing CRC-8 byte is enabled by defining TX_CRC_EN.
module tx_packet_framer
    import tx_framer_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = 4,
    parameter logic [7:0]  SFD_BYTE       = 8'hD5,
    parameter logic [1:0]  IDLE_SYM       = 2'b00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] len_in,
    input  logic       sym_en,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [3:0] PRE_N = 4'(PREAMBLE_BYTES);

    tx_state_e  r_state, w_state_nxt;
    logic [7:0] r_len, r_pay_left, r_fetch_left, r_hold;
    logic [3:0] r_pre_cnt;
    logic       r_hold_vld, r_loaded, r_rd_req, r_sym_valid, r_done, r_underrun;
    logic       w_load, w_take_hold, w_underrun_evt, w_fin_drop, w_done_set;
    logic       w_shift, w_clear, w_bnd;
    logic [7:0] w_load_data;
`ifdef TX_CRC_EN
    logic [7:0] r_crc;
`endif

    assign w_shift   = sym_en && (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign w_clear   = w_underrun_evt || w_fin_drop;
    assign rd_req    = r_rd_req;
    assign sym_valid = r_sym_valid;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign underrun  = r_underrun;

    tx_dibit_shifter #(.IDLE_SYM(IDLE_SYM)) u_shifter (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_load          (w_load),
        .i_load_data     (w_load_data),
        .i_shift         (w_shift),
        .i_clear         (w_clear),
        .o_sym           (sym_out),
        .o_byte_boundary (w_bnd)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_load_data    = PREAMBLE_BYTE;
        w_take_hold    = 1'b0;
        w_underrun_evt = 1'b0;
        w_fin_drop     = 1'b0;
        w_done_set     = 1'b0;
        case (r_state)
            ST_IDLE: if (start) begin
                w_load      = 1'b1;
                w_state_nxt = ST_PRE;
            end
            ST_PRE: if (w_bnd) begin
                w_load = 1'b1;
                if (r_pre_cnt == PRE_N) begin
                    w_load_data = SFD_BYTE;
                    w_state_nxt = ST_SFD;
                end
            end
            ST_SFD: if (w_bnd) begin
                w_load      = 1'b1;
                w_load_data = r_len;
                w_state_nxt = ST_LEN;
            end
            ST_LEN, ST_PAY: if (w_bnd) begin
                if (r_pay_left != 8'd0) begin
                    if (r_hold_vld) begin
                        w_load      = 1'b1;
                        w_load_data = r_hold;
                        w_take_hold = 1'b1;
                        w_state_nxt = ST_PAY;
                    end else begin
                        w_underrun_evt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end else begin
`ifdef TX_CRC_EN
                    w_load      = 1'b1;
                    w_load_data = r_crc;
                    w_state_nxt = ST_CRC;
`else
                    w_state_nxt = ST_FIN;
`endif
                end
            end
            ST_CRC: if (w_bnd) w_state_nxt = ST_FIN;
            // First strobe in FIN retires the last dibit; done follows once valid is low.
            ST_FIN: if (r_sym_valid) begin
                if (sym_en) w_fin_drop = 1'b1;
            end else begin
                w_done_set  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_len        <= 8'h00;
            r_pay_left   <= 8'h00;
            r_fetch_left <= 8'h00;
            r_hold       <= 8'h00;
            r_pre_cnt    <= 4'd0;
            r_hold_vld   <= 1'b0;
            r_loaded     <= 1'b0;
            r_rd_req     <= 1'b0;
            r_sym_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_loaded <= w_load;
            r_done   <= w_done_set;
            // One-deep holding register: fetch only once the previous byte has been consumed.
            r_rd_req <= r_loaded && (r_state != ST_IDLE) && !r_hold_vld && (r_fetch_left != 8'd0);
            if (r_rd_req) r_fetch_left <= r_fetch_left - 8'd1;
            if (w_take_hold) begin
                r_hold_vld <= 1'b0;
                r_pay_left <= r_pay_left - 8'd1;
            end else if (rd_valid && (r_state != ST_IDLE)) begin
                r_hold     <= rd_data;
                r_hold_vld <= 1'b1;
            end
            if (w_shift) r_sym_valid <= 1'b1;
            if (w_clear) r_sym_valid <= 1'b0;
            if (w_underrun_evt) r_underrun <= 1'b1;
            if ((r_state == ST_PRE) && w_load) r_pre_cnt <= r_pre_cnt + 4'd1;
            if ((r_state == ST_IDLE) && start) begin
                r_len        <= len_in;
                r_pay_left   <= len_in;
                r_fetch_left <= len_in;
                r_pre_cnt    <= 4'd1;
                r_hold_vld   <= 1'b0;
                r_underrun   <= 1'b0;
            end
        end
    end

`ifdef TX_CRC_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= 8'h00;
        end else if ((r_state == ST_IDLE) && start) begin
            r_crc <= 8'h00;
        end else if (w_load && ((r_state == ST_SFD) || w_take_hold)) begin
            r_crc <= crc8_byte(r_crc, w_load_data);
        end
    end
`endif

endmodule
